elevator_request_scheduler: RTL
===============================

// Module: elevator_request_scheduler
// PURPOSE
//   Cab controller for an N-floor elevator. Latches hall/cab call pulses into a pending set
//   and serves them with a SCAN (keep-direction) policy. Times inter-floor travel and
//   door dwell with cycle counters. Drives cur_floor/moving/door_open for the cab
//   datapath and floor displays.
// PARAMETERS
//   N_FLOORS    4   number of floors, numbered 0..N_FLOORS-1 (floor 0 = ground/home)
//   FLOOR_W     2   width of floor index, = clog2(N_FLOORS)
//   TRAVEL_CYC  8   clock cycles to travel one floor (>=1)
//   DOOR_CYC    4   clock cycles door stays open after last service request (>=1)
// PORTS
//   clk        in   1         clock, all state updates on rising edge
//   rst_n      in   1         synchronous reset, active low
//   req        in   N_FLOORS  call pulses/levels, bit i = call for floor i
//   cur_floor  out  FLOOR_W   current floor of the cab
//   moving     out  1         1 while travelling between floors
//   dir_up     out  1         current/last travel direction, 1 = up
//   door_open  out  1         1 while door is open at cur_floor
//   arrive     out  1         1-cycle pulse on the first cycle at a floor being served
//   pending    out  N_FLOORS  latched unserved calls
// BEHAVIOUR
//   Reset: rst_n low at a rising edge -> state IDLE, cur_floor=0, moving=0, dir_up=1,
//     door_open=0, arrive=0, pending=0, timers=0; req ignored that cycle. Applies mid-travel
//     or mid-door: operation aborts, cab returns to floor 0 state immediately.
//   Pending: pending[i] <= pending[i] | req[i] each cycle; bit cleared on the edge that enters
//     DOOR_OPEN at floor i. All scheduling decisions use the registered pending value, so a
//     req is visible to the FSM one cycle after it is sampled.
//   States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. All outputs registered.
//   IDLE: pending==0 -> stay. pending[cur_floor] -> DOOR_OPEN (no travel, arrive=1).
//     Else above = any pending[j], j>cur_floor; below = any j<cur_floor.
//     dir_up&above or !below -> MOVE_UP, dir_up=1; else MOVE_DOWN, dir_up=0.
//     Entering MOVE loads travel timer with TRAVEL_CYC-1; moving=1.
//   MOVE_x: timer decrements each cycle; on the cycle timer==0 the edge updates cur_floor
//     +/-1, so moving is high exactly TRAVEL_CYC cycles per floor. At that edge, using the
//     new floor f: pending[f] -> DOOR_OPEN (moving=0, door_open=1, arrive=1, pending[f]
//     cleared); else calls remain ahead in dir -> stay in MOVE_x, reload timer; else IDLE.
//     cur_floor never exceeds N_FLOORS-1 nor goes below 0 (no wrap).
//   DOOR_OPEN: door timer loaded DOOR_CYC-1 on entry; door_open=1 for DOOR_CYC cycles.
//     req[cur_floor] arriving while open -> timer reloads to DOOR_CYC-1, pending bit stays 0.
//     Timer==0 -> IDLE, door_open=0; next decision made from IDLE the following cycle.
//   arrive: high only on the first DOOR_OPEN cycle; 0 in all other cycles.
//   Simultaneous calls resolved by SCAN only; no fairness beyond direction ordering.
//   Latency: req edge -> pending (+1) -> IDLE decides, MOVE entered (+1) -> arrive after
//     |target-cur|*TRAVEL_CYC further cycles.
// TESTING (defaults N_FLOORS=4, TRAVEL_CYC=8, DOOR_CYC=4)
//   1 Reset: rst_n=0 two cycles, req=4'b1111 -> cur_floor=0, moving=0, door_open=0,
//     pending=0, dir_up=1, arrive=0.
//   2 Single call: idle at 0, pulse req=4'b0100 -> moving=1 16 cycles, cur_floor 1 after 8,
//     2 after 16 with arrive=1, door_open=1 4 cycles, pending=0, then IDLE.
//   3 SCAN order: travelling up from 1 toward 3, pulse req[0] and req[2] -> arrivals at 2,
//     then 3, then dir_up=0 and arrival at 0; arrive pulses exactly 3 times.
//   4 Door extend: at floor 2 door open, pulse req[2] on 3rd open cycle -> door_open stays
//     high 4 cycles after that pulse, no second arrive pulse, pending[2]=0.
//   5 Reset mid-travel: rst_n=0 while moving from 2 to 3 -> next cycle cur_floor=0,
//     moving=0, pending=0, IDLE; no arrive pulse.
//   6 All floors: at 0 idle, req=4'b1111 -> door at 0, then serves 1,2,3 in order,
//     cur_floor max 3, pending=0 at end.

Source files
------------

// File: rtl/elevator_request_scheduler_if.sv
// Call/status bundle between the elevator scheduler and its cab datapath/floor displays.
// master drives the call lines; slave is the scheduler.
interface elevator_request_scheduler_if #(
  parameter int unsigned N_FLOORS = 4,
  parameter int unsigned FLOOR_W  = 2
);
  logic [N_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]  cur_floor;
  logic                moving;
  logic                dir_up;
  logic                door_open;
  logic                arrive;
  logic [N_FLOORS-1:0] pending;

  modport master (
    output req,
    input  cur_floor, moving, dir_up, door_open, arrive, pending
  );

  modport slave (
    input  req,
    output cur_floor, moving, dir_up, door_open, arrive, pending
  );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN cab controller: latches floor calls, times travel and door dwell with one shared
// down-counter, and keeps travelling in the current direction while calls remain ahead.
module elevator_request_scheduler #(
  parameter int unsigned N_FLOORS   = 4,
  parameter int unsigned FLOOR_W    = 2,
  parameter int unsigned TRAVEL_CYC = 8,
  parameter int unsigned DOOR_CYC   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  elevator_request_scheduler_if.slave   bus
);

  localparam int unsigned TMR_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0]   TRAVEL_LOAD = TMR_W'(TRAVEL_CYC - 1);
  localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

  typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoorOpen} state_e;

  state_e              state_q;
  logic [FLOOR_W-1:0]  floor_q;
  logic                moving_q;
  logic                dir_up_q;
  logic                door_q;
  logic                arrive_q;
  logic [N_FLOORS-1:0] pending_q;
  logic [TMR_W-1:0]    timer_q;

  logic                above, below, ahead;
  logic [FLOOR_W-1:0]  next_floor;
  logic [N_FLOORS-1:0] cur_mask, next_mask, pend_acc;

  assign bus.cur_floor = floor_q;
  assign bus.moving    = moving_q;
  assign bus.dir_up    = dir_up_q;
  assign bus.door_open = door_q;
  assign bus.arrive    = arrive_q;
  assign bus.pending   = pending_q;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int j = 0; j < int'(N_FLOORS); j++) begin
      if (pending_q[j] && (j > int'(floor_q))) above = 1'b1;
      if (pending_q[j] && (j < int'(floor_q))) below = 1'b1;
    end
    // Floor reached at the end of the current hop; clamped so the cab never wraps.
    next_floor = floor_q;
    if (state_q == StMoveUp && floor_q != TOP_FLOOR) begin
      next_floor = floor_q + FLOOR_W'(1);
    end else if (state_q == StMoveDown && floor_q != '0) begin
      next_floor = floor_q - FLOOR_W'(1);
    end
    ahead = 1'b0;
    for (int j = 0; j < int'(N_FLOORS); j++) begin
      if (pending_q[j] && (((state_q == StMoveUp) && (j > int'(next_floor))) ||
                           ((state_q == StMoveDown) && (j < int'(next_floor))))) begin
        ahead = 1'b1;
      end
    end
    cur_mask  = N_FLOORS'(1) << floor_q;
    next_mask = N_FLOORS'(1) << next_floor;
    pend_acc  = pending_q | bus.req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      floor_q   <= '0;
      moving_q  <= 1'b0;
      dir_up_q  <= 1'b1;
      door_q    <= 1'b0;
      arrive_q  <= 1'b0;
      pending_q <= '0;
      timer_q   <= '0;
    end else begin
      arrive_q  <= 1'b0;
      pending_q <= pend_acc;
      unique case (state_q)
        StIdle: begin
          if (pending_q[floor_q]) begin
            state_q   <= StDoorOpen;
            door_q    <= 1'b1;
            arrive_q  <= 1'b1;
            timer_q   <= DOOR_LOAD;
            pending_q <= pend_acc & ~cur_mask;
          end else if (|pending_q) begin
            moving_q <= 1'b1;
            timer_q  <= TRAVEL_LOAD;
            if ((dir_up_q && above) || !below) begin
              state_q  <= StMoveUp;
              dir_up_q <= 1'b1;
            end else begin
              state_q  <= StMoveDown;
              dir_up_q <= 1'b0;
            end
          end
        end
        StMoveUp, StMoveDown: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TMR_W'(1);
          end else begin
            floor_q <= next_floor;
            if (pending_q[next_floor]) begin
              state_q   <= StDoorOpen;
              moving_q  <= 1'b0;
              door_q    <= 1'b1;
              arrive_q  <= 1'b1;
              timer_q   <= DOOR_LOAD;
              pending_q <= pend_acc & ~next_mask;
            end else if (ahead) begin
              timer_q <= TRAVEL_LOAD;
            end else begin
              state_q  <= StIdle;
              moving_q <= 1'b0;
            end
          end
        end
        StDoorOpen: begin
          // A call for the open floor holds the door rather than queueing a revisit.
          pending_q <= pend_acc & ~cur_mask;
          if (bus.req[floor_q]) begin
            timer_q <= DOOR_LOAD;
          end else if (timer_q == '0) begin
            state_q <= StIdle;
            door_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
